imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It replaces the single-format 14-bit combinational sign extender with multiple immediate formats: signed, unsigned, scaled branch offset and upper immediate. The block adds a two-stage valid/ready pipeline, a pass-through tag, flush support and an illegal-format flag. It sits between instruction fetch/decode and the register-read/execute boundary.

Parameters:
XLEN, 32, width of extended immediate output
INSTR_W, 32, instruction word width
IMM_W, 14, width of arithmetic/memory immediate field In[IMM_W-1:0]
BR_W, 18, width of branch offset field In[BR_W-1:0]
BR_SHIFT, 2, left shift applied to branch offset (instruction alignment)
UP_W, 18, width of upper-immediate field In[UP_W-1:0]
TAG_W, 5, width of sideband tag (e.g. destination register/ROB id)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  discard all in-flight entries
in_valid  in  1  input entry valid
in_ready  out  1  block can accept input this cycle
in_instr  in  INSTR_W  instruction word
in_imm_src  in  3  immediate format select
in_tag  in  TAG_W  sideband tag, passed through unchanged
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts output
out_imm  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of the output entry
out_illegal  out  1  in_imm_src was unsupported for this entry

Behaviour:
- Elaboration checks:
  - IMM_W, BR_W and UP_W must each be <= INSTR_W.
  - IMM_W and UP_W must each be <= XLEN.
  - BR_W+BR_SHIFT must be <= XLEN.
  - Any violation is a fatal elaboration error.
- Format encoding of in_imm_src:
  - 000: sign-extend In[IMM_W-1:0].
  - 001: zero-extend In[IMM_W-1:0].
  - 010: sign-extend In[BR_W-1:0] to XLEN, then shift left by BR_SHIFT; shifted-out MSBs are discarded and LSBs are zero-filled.
  - 011: In[UP_W-1:0] placed at bits [XLEN-1:XLEN-UP_W], lower bits zero.
  - 100: sign-extend In[IMM_W-1:0] (memory offset; same as 000, kept as a distinct code for future scaling).
  - 101-111: illegal; out_imm=0 and out_illegal=1.
- Pipeline:
  - S1 registers instr, src and tag on each accept (in_valid && in_ready).
  - S2 registers the computed imm, illegal flag and tag.
  - Latency is exactly 2 cycles from accept to out_valid when out_ready is held high.
- Handshake:
  - s2_free = !s2_valid || out_ready; S1 advances into S2 when s1_valid && s2_free.
  - in_ready = !flush && (!s1_valid || s2_free). This is combinational and gives full throughput of 1 entry per cycle.
  - An output transfer occurs when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_imm, out_tag and out_illegal must hold stable.
- Stalling:
  - With out_ready low, at most 2 entries are held (S1+S2).
  - in_ready drops once both stages are occupied.
  - Entry order is always preserved.
- Flush:
  - On the edge where flush=1, s1_valid and s2_valid clear to 0.
  - in_ready=0 while flush=1, so no entry is accepted in a flush cycle.
  - An output transfer handshaked in the flush cycle still counts as delivered.
  - out_valid is 0 the cycle after flush.
- Reset: asynchronous, immediate on rst rising.
  - s1_valid, s2_valid, out_valid = 0.
  - out_imm = 0, out_tag = 0, out_illegal = 0; all internal data registers = 0.
  - in_ready is 1 after reset deassertion (flush low).
  - Reset mid-stall discards held entries; no partial entry may appear afterwards.
- Data registers need not change when their stage is idle; outputs are only meaningful when out_valid=1.

Test Plan:
- Defaults, out_ready=1: src=000, In[13:0]=0x2000 -> 2 cycles later out_imm=0xFFFFE000, out_illegal=0. Same instr with src=001 -> 0x00002000. With In[13:0]=0x1FFF and src=000 -> 0x00001FFF.
- src=010 with In[17:0]=0x20000 -> 0xFFF80000. With In[17:0]=0x00005 -> 0x00000014. src=011 with In[17:0]=0x00001 -> 0x00004000.
- src=110, tag=0x1A -> out_imm=0x00000000, out_illegal=1, out_tag=0x1A.
- Back-to-back entries A, B, C offered every cycle with out_ready=0:
  - A and B are accepted, then in_ready=0 and C is held.
  - out_imm stays stable on A.
  - After out_ready rises, outputs are A, B, C in order, one per cycle, with no duplicates or drops.
- Two entries in flight, flush=1 for one cycle with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, and no flushed or flush-cycle entry ever emerges. The first entry after flush has 2-cycle latency.
- Assert rst asynchronously between clock edges while stalled with 2 entries -> out_valid and out_imm go to 0 immediately. After release, in_ready=1 and the first new entry appears after 2 cycles.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator: S1 captures the raw instruction/format/tag,
// S2 holds the extended immediate. Two-entry valid/ready pipeline with flush.
module imm_ext_pipe #(
    parameter int XLEN     = 32,
    parameter int INSTR_W  = 32,
    parameter int IMM_W    = 14,
    parameter int BR_W     = 18,
    parameter int BR_SHIFT = 2,
    parameter int UP_W     = 18,
    parameter int TAG_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [2:0]         in_imm_src,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    if (IMM_W > INSTR_W || BR_W > INSTR_W || UP_W > INSTR_W ||
        IMM_W > XLEN || UP_W > XLEN || (BR_W + BR_SHIFT) > XLEN) begin : g_param_err
        $fatal(1, "imm_ext_pipe: immediate field widths incompatible with INSTR_W/XLEN");
    end

    logic               s1_valid;
    logic [INSTR_W-1:0] s1_instr;
    logic [2:0]         s1_src;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_valid;
    logic [XLEN-1:0]    s2_imm;
    logic               s2_illegal;
    logic [TAG_W-1:0]   s2_tag;

    logic               s2_free;
    logic               accept;
    logic [XLEN-1:0]    imm_c;
    logic               ill_c;
    logic [XLEN-1:0]    br_ext;
    logic               s1_unused;

    // Instruction bits above the widest field are never decoded.
    assign s1_unused = ^s1_instr;

    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !flush && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        imm_c  = '0;
        ill_c  = 1'b0;
        br_ext = XLEN'($signed(s1_instr[BR_W-1:0]));
        case (s1_src)
            3'b000, 3'b100: imm_c = XLEN'($signed(s1_instr[IMM_W-1:0]));
            3'b001:         imm_c = XLEN'(s1_instr[IMM_W-1:0]);
            3'b010:         imm_c = br_ext << BR_SHIFT;
            3'b011:         imm_c = XLEN'(s1_instr[UP_W-1:0]) << (XLEN - UP_W);
            default:        ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_instr   <= '0;
            s1_src     <= '0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_imm     <= '0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_imm     <= imm_c;
                    s2_illegal <= ill_c;
                    s2_tag     <= s1_tag;
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_instr <= in_instr;
                s1_src   <= in_imm_src;
                s1_tag   <= in_tag;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_imm     = s2_imm;
    assign out_tag     = s2_tag;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: accepted entries are modelled arithmetically
// and queued; a negedge monitor compares every presented output against the queue head.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, out_imm;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag, out_tag;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    imm_ext_pipe #(.XLEN(32), .INSTR_W(32), .IMM_W(14), .BR_W(18), .BR_SHIFT(2),
                   .UP_W(18), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: field value as an integer, sign-adjusted, scaled, truncated to 32 bits.
    function automatic exp_t model(input logic [31:0] instr, input logic [2:0] src,
                                   input logic [4:0] tag);
        longint f;
        exp_t e;
        e.tag = tag;
        e.ill = 1'b0;
        f = 0;
        case (src)
            3'd0, 3'd4: begin
                f = longint'(instr) % 16384;
                if (f >= 8192) f = f - 16384;
            end
            3'd1: f = longint'(instr) % 16384;
            3'd2: begin
                f = longint'(instr) % 262144;
                if (f >= 131072) f = f - 262144;
                f = f * 4;
            end
            3'd3: f = (longint'(instr) % 262144) * 16384;
            default: e.ill = 1'b1;
        endcase
        e.imm = f[31:0];
        return e;
    endfunction

    // Monitor: output must match the oldest outstanding entry, and hold while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("out_imm", out_imm, q[0].imm);
                check("out_tag", 32'(out_tag), 32'(q[0].tag));
                check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Acceptance sampler, just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (flush) q.delete();
                else if (in_valid && in_ready) q.push_back(model(in_instr, in_imm_src, in_tag));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [4:0] tag);
        in_valid   = v;
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
    endtask

    // Single entry into an empty pipe with out_ready high: exactly 2-cycle latency.
    task automatic lat(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag,
                       input logic [31:0] exp_imm, input logic exp_ill);
        cyc();
        out_ready = 1'b1;
        drive(1'b1, instr, src, tag);
        #1;
        check("lat_in_ready", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, '0, '0, '0);
        #1;
        check("lat_early", 32'(out_valid), 32'd0);
        cyc();
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_imm", out_imm, exp_imm);
        check("lat_ill", 32'(out_illegal), 32'(exp_ill));
        check("lat_tag", 32'(out_tag), 32'(tag));
        cyc();
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            cyc();
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_ill", 32'(out_illegal), 32'd0);
        #6 rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        lat(32'h0000_2000, 3'd0, 5'd1, 32'hFFFF_E000, 1'b0);
        lat(32'h0000_2000, 3'd1, 5'd2, 32'h0000_2000, 1'b0);
        lat(32'h0000_1FFF, 3'd0, 5'd3, 32'h0000_1FFF, 1'b0);
        lat(32'h0002_0000, 3'd2, 5'd4, 32'hFFF8_0000, 1'b0);
        lat(32'h0000_0005, 3'd2, 5'd5, 32'h0000_0014, 1'b0);
        lat(32'h0000_0001, 3'd3, 5'd6, 32'h0000_4000, 1'b0);
        lat(32'hFFFF_2000, 3'd4, 5'd7, 32'hFFFF_E000, 1'b0);
        lat(32'h1234_5678, 3'd6, 5'h1A, 32'h0000_0000, 1'b1);

        // Stall: A and B accepted, C held off until the output side drains.
        cyc();
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_3001, 3'd0, 5'd10);
        cyc();
        drive(1'b1, 32'h0000_0007, 3'd1, 5'd11);
        cyc();
        drive(1'b1, 32'h0003_FFFF, 3'd2, 5'd12);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        cyc();
        cyc();
        check("stall_in_ready2", 32'(in_ready), 32'd0);
        check("stall_q_depth", 32'(q.size()), 32'd2);
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, '0, '0, '0);
        drain("stall_drain");

        // Flush with two entries in flight and a competing input.
        cyc();
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0100, 3'd0, 5'd20);
        cyc();
        drive(1'b1, 32'h0000_0200, 3'd1, 5'd21);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'h0000_0300, 3'd0, 5'd22);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        lat(32'h0000_0ABC, 3'd1, 5'd23, 32'h0000_0ABC, 1'b0);

        // Asynchronous reset while stalled with two entries.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_2222, 3'd0, 5'd24);
        cyc();
        drive(1'b1, 32'h0000_3333, 3'd0, 5'd25);
        cyc();
        drive(1'b0, '0, '0, '0);
        cyc();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_imm", out_imm, 32'd0);
        #4;
        rst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        lat(32'h0000_0001, 3'd0, 5'd26, 32'h0000_0001, 1'b0);

        // Randomized traffic with random backpressure and occasional flushes.
        for (int n = 0; n < 600; n++) begin
            cyc();
            drive(($urandom % 4) != 0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 40) == 0;
        end
        cyc();
        drain("random_drain");

        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
